// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encodings, parity types and counter sizing for the UART transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  function automatic int cnt_w(input int dw);
    return (dw <= 1) ? 1 : $clog2(dw);
  endfunction
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first shift register and data-bit counter for one frame
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic                  i_cnt_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ser_data,
  output logic                  o_ser_done
);
  localparam int CW = cnt_w(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  assign o_ser_data = r_shift[0];
  assign o_ser_done = i_cnt_en && (r_cnt == CW'(DATA_WIDTH - 1));
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else begin
      if (i_shift) r_shift <= r_shift >> 1;
      if (i_cnt_en) r_cnt <= o_ser_done ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: frame FSM with registered serial line and busy flag
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);
  state_t r_state, w_next;
  logic   r_par, r_par_en, w_tx, w_load, w_ser_data, w_ser_done;
  assign w_load = (r_state == IDLE) && Data_Valid;
  // shifting starts in START so the next data bit is ready when TX_OUT is loaded
  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_load),
    .i_shift    ((r_state == START) || (r_state == DATA)),
    .i_cnt_en   (r_state == DATA),
    .i_data     (P_DATA),
    .o_ser_data (w_ser_data),
    .o_ser_done (w_ser_done)
  );
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = Data_Valid ? START : IDLE;
      START:   w_next = DATA;
      DATA:    w_next = w_ser_done ? (r_par_en ? PARITY : STOP) : DATA;
      PARITY:  w_next = STOP;
      STOP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_tx = (w_next == START) ? 1'b0 : (w_next == DATA) ? w_ser_data : (w_next == PARITY) ? r_par : 1'b1;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
    end else begin
      r_state <= w_next;
      TX_OUT  <= w_tx;
      Busy    <= (w_next != IDLE);
      if (w_load) begin
        r_par    <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        r_par_en <= PAR_EN;
      end
    end
  end
endmodule
